// File: rtl/cmd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cmd_sched_pkg
// Brief   : State encoding, command byte values and byte decoder for cmd_scheduler.
// Rev     : 1.0
// ============================================================================
package cmd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    COOLDOWN = 2'd2
  } sched_state_t;

  localparam logic [3:0] CMD_RUN_PREFIX = 4'h1;
  localparam logic [7:0] CMD_ABORT      = 8'h00;
  localparam logic [7:0] CMD_CLEAR      = 8'hFF;

  typedef struct packed {
    logic run;
    logic abort;
    logic clear;
    logic bad;
  } cmd_dec_t;

  // Exactly one field is set for any byte; RUN to a missing unit counts as bad.
  function automatic cmd_dec_t decode_cmd(input logic [7:0] cmd_byte, input int n_units);
    cmd_dec_t d;
    d = '0;
    if (cmd_byte == CMD_ABORT) begin
      d.abort = 1'b1;
    end else if (cmd_byte == CMD_CLEAR) begin
      d.clear = 1'b1;
    end else if (cmd_byte[7:4] == CMD_RUN_PREFIX && int'(cmd_byte[3:0]) < n_units) begin
      d.run = 1'b1;
    end else begin
      d.bad = 1'b1;
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sched_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : sched_watchdog
// Brief   : Saturating cycle counter; expired is high once TIMEOUT_CYCLES is reached.
// Rev     : 1.0
// ============================================================================
module sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   C_LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && r_count != C_LIMIT) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : cmd_scheduler
// Brief   : Decodes UART command bytes and runs one function unit at a time.
//           Define CMD_SCHED_WATCHDOG_EN to enable the hung-command watchdog.
// Rev     : 1.0
// ============================================================================
module cmd_scheduler
  import cmd_sched_pkg::*;
#(
  parameter int N_UNITS        = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk_50mhz,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_ready,
  input  logic [N_UNITS-1:0] done,
  output logic [N_UNITS-1:0] activate,
  output logic [7:0]         status,
  output logic               busy,
  output logic               err_cmd,
  output logic               err_busy,
  output logic               err_timeout
);

  if (N_UNITS < 1 || N_UNITS > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("cmd_scheduler: N_UNITS or TIMEOUT_CYCLES out of range");
  end

  sched_state_t       r_state, w_state_nxt;
  cmd_dec_t           w_cmd;
  logic [N_UNITS-1:0] r_sel, w_sel_nxt;
  logic [N_UNITS-1:0] r_activate, w_activate_nxt;
  logic [7:0]         r_status, w_status_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_err_cmd, w_err_cmd_nxt;
  logic               r_err_busy, w_err_busy_nxt;
  logic               r_err_timeout, w_err_timeout_nxt;
  logic               w_launch, w_done_k, w_expired;

  assign w_cmd    = rx_ready ? decode_cmd(rx_data, N_UNITS) : '0;
  assign w_launch = (r_state == IDLE) && w_cmd.run;
  assign w_done_k = |(done & r_sel);

`ifdef CMD_SCHED_WATCHDOG_EN
  sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk_50mhz),
    .reset  (reset),
    .clear  (w_launch),
    .enable (r_state != IDLE),
    .expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Watchdog beats done/abort; done beats abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_cmd.run) w_state_nxt = RUN;
      RUN: begin
        if (w_expired)                    w_state_nxt = IDLE;
        else if (w_done_k || w_cmd.abort) w_state_nxt = COOLDOWN;
      end
      COOLDOWN: if (w_expired || !w_done_k) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt    = r_sel;
    w_status_nxt = r_status;
    if (w_launch) begin
      for (int i = 0; i < N_UNITS; i++) w_sel_nxt[i] = (int'(rx_data[3:0]) == i);
      w_status_nxt = rx_data;
    end
    if (w_state_nxt == IDLE) w_status_nxt = 8'h00;
    w_activate_nxt    = (w_state_nxt == RUN) ? w_sel_nxt : '0;
    w_busy_nxt        = (w_state_nxt != IDLE);
    // Sticky flags: a set on the same cycle as CLEAR survives.
    w_err_cmd_nxt     = w_cmd.bad | (r_err_cmd & ~w_cmd.clear);
    w_err_busy_nxt    = (w_cmd.run & (r_state != IDLE)) | (r_err_busy & ~w_cmd.clear);
    w_err_timeout_nxt = (w_expired & (r_state != IDLE)) | (r_err_timeout & ~w_cmd.clear);
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      r_sel         <= '0;
      r_activate    <= '0;
      r_status      <= 8'h00;
      r_busy        <= 1'b0;
      r_err_cmd     <= 1'b0;
      r_err_busy    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_sel         <= w_sel_nxt;
      r_activate    <= w_activate_nxt;
      r_status      <= w_status_nxt;
      r_busy        <= w_busy_nxt;
      r_err_cmd     <= w_err_cmd_nxt;
      r_err_busy    <= w_err_busy_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  assign activate    = r_activate;
  assign status      = r_status;
  assign busy        = r_busy;
  assign err_cmd     = r_err_cmd;
  assign err_busy    = r_err_busy;
  assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_cmd_scheduler
// Brief   : Scoreboard bench for cmd_scheduler with unit models and random commands.
// Rev     : 1.0
// ============================================================================
module tb_cmd_scheduler;

  localparam int N   = 4;
  localparam int T   = 16;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_ready = 1'b0;
  logic [N-1:0] done = '0;
  logic [N-1:0] activate;
  logic [7:0]   status;
  logic         busy, err_cmd, err_busy, err_timeout;

  always #5 clk = ~clk;

  cmd_scheduler #(.N_UNITS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_50mhz(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .done(done), .activate(activate), .status(status), .busy(busy),
    .err_cmd(err_cmd), .err_busy(err_busy), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [7:0]   status;
    logic [N-1:0] onehot;
    int           act_len;
    int           busy_len;
  } tx_t;

  tx_t        tx_q[$];
  logic [2:0] flag_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  // Reference model state: flags {cmd,busy,timeout} and the current run window.
  logic [2:0]   m_flags = 3'b000;
  bit           m_active = 0;
  int           m_e = 0, m_act = 0, m_dur = 0;
  logic [N-1:0] unit_en = '1;
  int           ucnt[N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Unit models: done rises LAT cycles after activate, drops once activate drops.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (!reset || !activate[k]) begin
          ucnt[k] = 0;
          done[k] = 1'b0;
        end else if (unit_en[k]) begin
          ucnt[k]++;
          if (ucnt[k] >= LAT) done[k] = 1'b1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_cmd(input logic [7:0] b, input int x);
    bit         busy_now, tmo;
    logic [2:0] nf;
    int         k;
    tx_t        t;
    busy_now = m_active && (x <= m_e + m_dur);
    nf  = m_flags;
    tmo = 0;
    if (b == 8'hFF) begin
      nf = 3'b000;
    end else if (b == 8'h00) begin
      if (busy_now && (x - m_e) < m_act) begin
        m_act = x - m_e;
        m_dur = m_act + 1;
        tx_q[tx_q.size()-1].act_len  = m_act;
        tx_q[tx_q.size()-1].busy_len = m_dur;
      end
    end else if (b[7:4] == 4'h1 && int'(b[3:0]) < N) begin
      if (busy_now) begin
        nf[1] = 1'b1;
      end else begin
        k = int'(b[3:0]);
        m_active = 1;
        m_e = x;
        if (unit_en[k]) begin
          m_act = LAT;
          m_dur = LAT + 1;
        end else begin
`ifdef CMD_SCHED_WATCHDOG_EN
          m_act = T + 1;
          m_dur = T + 1;
          tmo   = 1;
`else
          m_act = 1000;
          m_dur = 1001;
`endif
        end
        t.status = b;
        t.onehot = '0;
        t.onehot[k] = 1'b1;
        t.act_len  = m_act;
        t.busy_len = m_dur;
        tx_q.push_back(t);
      end
    end else begin
      nf[2] = 1'b1;
    end
    if (nf != m_flags) flag_q.push_back(nf);
    m_flags = nf;
    if (tmo && !m_flags[0]) begin
      m_flags[0] = 1'b1;
      flag_q.push_back(m_flags);
    end
  endtask

  task automatic send(input logic [7:0] b);
    model_cmd(b, cyc + 1);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle();
    while (m_active && (cyc + 1 <= m_e + m_dur)) idle(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_activate"}, activate, 0);
    check({tag, "_status"}, status, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_flags"}, {err_cmd, err_busy, err_timeout}, 0);
  endtask

  // Monitor: launch and completion events pop the transaction queue, flag edges pop the flag queue.
  initial begin
    bit         pb;
    logic [2:0] pf, fl;
    int         ac, bc;
    tx_t        t;
    pb = 0; pf = 3'b000; ac = 0; bc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pb = 0; pf = 3'b000;
        continue;
      end
      fl = {err_cmd, err_busy, err_timeout};
      if (busy && !pb) begin
        ac = 0; bc = 0;
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_launch: got activate=%b status=%h expected no launch", activate, status);
        end else begin
          check("launch_activate", activate, tx_q[0].onehot);
          check("launch_status", status, tx_q[0].status);
        end
      end
      if (busy) begin
        bc++;
        if (activate != 0) ac++;
      end
      if (!busy && pb && tx_q.size() != 0) begin
        t = tx_q.pop_front();
        check("active_cycles", ac, t.act_len);
        check("busy_cycles", bc, t.busy_len);
        check("end_status", status, 0);
        check("end_activate", activate, 0);
      end
      if (fl != pf) begin
        if (flag_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_flags: got %b expected %b", fl, pf);
        end else begin
          check("flags", fl, flag_q.pop_front());
        end
      end
      pb = busy;
      pf = fl;
    end
  end

  initial begin
    logic [7:0] b;
    int         r;
    idle(3);
    check_reset_values("reset");
    #3 reset = 1'b1;
    idle(1);

    // Plain run of unit 2
    send(8'h12);
    wait_idle();
    idle(1);

    // Overlapping RUN, then CLEAR
    send(8'h13);
    idle(2);
    send(8'h11);
    wait_idle();
    send(8'hFF);
    idle(2);

    // Undecodable bytes in IDLE
    send(8'h17);
    idle(2);
    send(8'h42);
    idle(2);

    // Hung unit 1
    unit_en[1] = 1'b0;
    send(8'h11);
`ifndef CMD_SCHED_WATCHDOG_EN
    idle(19);
    send(8'h00);
`endif
    wait_idle();
    unit_en[1] = 1'b1;
    idle(1);
    send(8'hFF);
    idle(2);

    // ABORT coinciding with done, then ABORT two cycles earlier
    send(8'h10);
    idle(LAT - 1);
    send(8'h00);
    wait_idle();
    idle(1);
    send(8'h10);
    idle(LAT - 3);
    send(8'h00);
    wait_idle();
    idle(1);

    // Asynchronous reset mid-run
    send(8'h12);
    idle(2);
    #2 reset = 1'b0;
    #1 check_reset_values("midrun_reset");
    tx_q.delete();
    flag_q.delete();
    m_flags  = 3'b000;
    m_active = 0;
    idle(3);
    #3 reset = 1'b1;
    idle(1);
    send(8'h12);
    wait_idle();
    idle(1);

    // Random command stream
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      b = 8'h10 | 8'($urandom_range(0, N - 1));
      else if (r < 55) b = 8'h00;
      else if (r < 65) b = 8'hFF;
      else if (r < 75) b = 8'h10 | 8'($urandom_range(N, 15));
      else begin
        b = 8'($urandom_range(1, 254));
        while (b[7:4] == 4'h1) b = 8'($urandom_range(1, 254));
      end
      send(b);
      idle(int'($urandom_range(1, 8)));
    end

    idle(20);
    check("tx_queue_drained", tx_q.size(), 0);
    check("flag_queue_drained", flag_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
